// File: rtl/sign_extend_pkg.sv
// Shared mode encodings and default widths for the immediate extender.
package sign_extend_pkg;

  localparam int unsigned IN_W_DEF  = 16;
  localparam int unsigned OUT_W_DEF = 32;

  localparam logic [1:0] EXT_SIGN   = 2'b00;
  localparam logic [1:0] EXT_ZERO   = 2'b01;
  localparam logic [1:0] EXT_LUI    = 2'b10;
  localparam logic [1:0] EXT_BRANCH = 2'b11;

endpackage

// File: rtl/sign_extend_core.sv
// Purely combinational immediate extender: mode mux plus sign flag.
module sign_extend_core
  import sign_extend_pkg::*;
#(
  parameter int unsigned IN_W  = IN_W_DEF,
  parameter int unsigned OUT_W = OUT_W_DEF
) (
  input  logic [IN_W-1:0]  imm_i,
  input  logic [1:0]       mode_i,
  output logic [OUT_W-1:0] ext_o,
  output logic             neg_o
);

  logic signed [OUT_W-1:0] sext;

  assign sext  = {{(OUT_W-IN_W){imm_i[IN_W-1]}}, imm_i};
  assign neg_o = imm_i[IN_W-1];

  // Mode mux; unknown mode bits fall through to the default so the
  // single-cycle datapath always sees a sign-extended value.
  always_comb begin
    ext_o = sext;
    case (mode_i)
      EXT_SIGN:   ext_o = sext;
      EXT_ZERO:   ext_o = {{(OUT_W-IN_W){1'b0}}, imm_i};
      EXT_LUI:    ext_o = {imm_i, {(OUT_W-IN_W){1'b0}}};
      EXT_BRANCH: ext_o = {sext[OUT_W-3:0], 2'b00};
      default:    ext_o = sext;
    endcase
  end

endmodule

// File: rtl/sign_extend.sv
// Immediate extender top: combinational result plus a one-cycle registered
// copy with a valid flag for pipelined/debug consumers.
module sign_extend
  import sign_extend_pkg::*;
#(
  parameter int unsigned IN_W  = IN_W_DEF,
  parameter int unsigned OUT_W = OUT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  inst15_0,
  input  logic [1:0]       ext_mode,
  input  logic             in_valid,
  output logic [OUT_W-1:0] Extend32,
  output logic [OUT_W-1:0] Extend32_q,
  output logic             out_valid,
  output logic             imm_neg
);

  logic [OUT_W-1:0] ext_d, ext_q;
  logic             vld_d, vld_q;

  sign_extend_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .imm_i  (inst15_0),
    .mode_i (ext_mode),
    .ext_o  (Extend32),
    .neg_o  (imm_neg)
  );

  // Next-state: capture on in_valid, otherwise hold the value and drop valid.
  always_comb begin
    ext_d = ext_q;
    vld_d = 1'b0;
    if (in_valid) begin
      ext_d = Extend32;
      vld_d = 1'b1;
    end
  end

  // Output register; reset wins over a simultaneous capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      ext_q <= '0;
      vld_q <= 1'b0;
    end else begin
      ext_q <= ext_d;
      vld_q <= vld_d;
    end
  end

  assign Extend32_q = ext_q;
  assign out_valid  = vld_q;

endmodule

// File: tb/tb_sign_extend.sv
// Self-checking bench for sign_extend: directed vectors, register behaviour,
// random register streams and a full immediate x mode sweep.
module tb_sign_extend;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] inst15_0;
  logic [1:0]  ext_mode;
  logic        in_valid;
  logic [31:0] Extend32;
  logic [31:0] Extend32_q;
  logic        out_valid;
  logic        imm_neg;

  int n_chk = 0;
  int n_err = 0;

  // Expected register state
  logic [31:0] exp_q;
  logic        exp_v;

  sign_extend dut (
    .clk        (clk),
    .reset      (reset),
    .inst15_0   (inst15_0),
    .ext_mode   (ext_mode),
    .in_valid   (in_valid),
    .Extend32   (Extend32),
    .Extend32_q (Extend32_q),
    .out_valid  (out_valid),
    .imm_neg    (imm_neg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Reference: interpret the immediate as a number and apply the mode rule.
  function automatic logic [31:0] ref_ext(input int imm, input int mode);
    longint s;
    longint r;
    s = (imm >= 32768) ? longint'(imm) - 65536 : longint'(imm);
    case (mode)
      0:       r = s;
      1:       r = longint'(imm);
      2:       r = longint'(imm) * 65536;
      default: r = s * 4;
    endcase
    return r[31:0];
  endfunction

  task automatic drive(input int imm, input int mode, input logic rst, input logic iv);
    inst15_0 = 16'(imm);
    ext_mode = 2'(mode);
    reset    = rst;
    in_valid = iv;
  endtask

  // Advance one edge, update the expected register state, then check.
  task automatic step_chk(input string tag);
    logic [31:0] cur;
    cur = ref_ext(int'(inst15_0), int'(ext_mode));
    @(posedge clk);
    if (reset) begin
      exp_q = 32'h0;
      exp_v = 1'b0;
    end else if (in_valid) begin
      exp_q = cur;
      exp_v = 1'b1;
    end else begin
      exp_v = 1'b0;
    end
    #2;
    chk({tag, "_q"}, Extend32_q, exp_q);
    chk({tag, "_v"}, {31'h0, out_valid}, {31'h0, exp_v});
  endtask

  int dir_imm [9] = '{'h0001, 'h8001, 'hFFFF, 'h0000, 'h7FFF, 'h8001, 'h1234, 'hFFFF, 'h4000};
  int dir_mode[9] = '{0, 0, 0, 0, 0, 1, 2, 3, 3};
  logic [31:0] dir_exp[9] = '{32'h00000001, 32'hFFFF8001, 32'hFFFFFFFF, 32'h00000000,
                              32'h00007FFF, 32'h00008001, 32'h12340000, 32'hFFFFFFFC,
                              32'h00010000};

  initial begin
    exp_q = 32'h0;
    exp_v = 1'b0;
    drive(0, 0, 1'b1, 1'b0);

    // Reset for two cycles while the combinational path keeps tracking
    step_chk("rst0");
    drive('h8001, 0, 1'b1, 1'b1);
    #1;
    chk("rst_comb", Extend32, 32'hFFFF8001);
    step_chk("rst1");
    chk("rst_q_zero", Extend32_q, 32'h0);

    // Directed combinational vectors, including 0x7FFF/0x8000 boundaries
    drive(0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      drive(dir_imm[i], dir_mode[i], 1'b0, 1'b0);
      #1;
      chk($sformatf("dir%0d", i), Extend32, dir_exp[i]);
      chk($sformatf("dir%0d_neg", i), {31'h0, imm_neg}, {31'h0, dir_imm[i] >= 32768});
    end
    drive('h8000, 0, 1'b0, 1'b0);
    #1;
    chk("sign_8000", Extend32, 32'hFFFF8000);

    // Capture then hold
    drive('h8001, 0, 1'b0, 1'b1);
    step_chk("cap");
    chk("cap_val", Extend32_q, 32'hFFFF8001);
    drive('h1234, 2, 1'b0, 1'b0);
    step_chk("hold");
    chk("hold_val", Extend32_q, 32'hFFFF8001);

    // Reset and in_valid on the same edge: reset wins
    drive('h7FFF, 0, 1'b1, 1'b1);
    step_chk("prio");
    chk("prio_val", Extend32_q, 32'h0);

    // Random streams with back-to-back captures and occasional reset
    for (int i = 0; i < 400; i++) begin
      drive(int'($urandom_range(0, 65535)), int'($urandom_range(0, 3)),
            ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0));
      step_chk("rnd");
    end

    // Back-to-back burst right after reset release
    drive(0, 0, 1'b1, 1'b0);
    step_chk("b2b_rst");
    for (int i = 0; i < 8; i++) begin
      drive(int'($urandom_range(0, 65535)), i % 4, 1'b0, 1'b1);
      step_chk("b2b");
    end

    // Full sweep of immediates x modes on the combinational path
    drive(0, 0, 1'b0, 1'b0);
    for (int m = 0; m < 4; m++) begin
      for (int v = 0; v < 65536; v++) begin
        inst15_0 = 16'(v);
        ext_mode = 2'(m);
        #1;
        chk($sformatf("sweep_m%0d_%04h", m, v), Extend32, ref_ext(v, m));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
